// File: rtl/sync_fifo_ctr.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctr
// Brief    : Single-clock FIFO with occupancy count, almost-full/almost-empty
//            thresholds, standard or FWFT read, and sticky error flags.
// Revision : 1.0
// ============================================================================
module sync_fifo_ctr #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  parameter  int FWFT     = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [AW:0]      count,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] C_AF_LEVEL = AF_LEVEL[AW:0];
  localparam logic [AW:0] C_AE_LEVEL = AE_LEVEL[AW:0];
  localparam logic [AW:0] C_ONE      = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_head;

  // Full/empty come from pointers alone so they never see this cycle's requests.
  assign w_full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign w_empty  = (wr_ptr_q == rd_ptr_q);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_head   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + C_ONE;
    end
    if (w_rd_acc) begin
      rd_ptr_d = rd_ptr_q + C_ONE;
    end
    if (w_wr_acc && !w_rd_acc) begin
      count_d = count_q + C_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      count_d = count_q - C_ONE;
    end
  end

  // A new error in the same cycle as err_clr must survive the clear.
  always_comb begin
    ovf_d = (ovf_q & ~err_clr) | (wr_en & w_full);
    unf_d = (unf_q & ~err_clr) | (rd_en & w_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = w_empty ? '0 : w_head;
      assign rd_valid = ~w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= w_rd_acc;
          if (w_rd_acc) begin
            rd_data_q <= w_head;
          end
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = count_q;
  assign almost_full  = (count_q >= C_AF_LEVEL);
  assign almost_empty = (count_q <= C_AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctr.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctr
// Brief    : Directed bench for sync_fifo_ctr: standard instance and an FWFT
//            instance with AF=12/AE=4, both fed the same stimulus.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_ctr;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, err_clr;
  logic [7:0] wr_data;

  logic       full0, af0, rdv0, empty0, ae0, ovf0, unf0;
  logic [7:0] rd0;
  logic [4:0] cnt0;
  logic       full1, af1, rdv1, empty1, ae1, ovf1, unf1;
  logic [7:0] rd1;
  logic [4:0] cnt1;

  int checks   = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_ctr #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full0),
    .almost_full(af0), .rd_en(rd_en), .rd_data(rd0), .rd_valid(rdv0),
    .empty(empty0), .almost_empty(ae0), .count(cnt0), .err_clr(err_clr),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_ctr #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full1),
    .almost_full(af1), .rd_en(rd_en), .rd_data(rd1), .rd_valid(rdv1),
    .empty(empty1), .almost_empty(ae1), .count(cnt1), .err_clr(err_clr),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_levels(input int n);
    chk("count0", 32'(cnt0), 32'(n));
    chk("count1", 32'(cnt1), 32'(n));
    chk("af0", 32'(af0), 32'(n >= 14));
    chk("ae0", 32'(ae0), 32'(n <= 2));
    chk("af1", 32'(af1), 32'(n >= 12));
    chk("ae1", 32'(ae1), 32'(n <= 4));
    chk("full0", 32'(full0), 32'(n == 16));
    chk("empty1", 32'(empty1), 32'(n == 0));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_count0", 32'(cnt0), 0);
    chk("rst_empty0", 32'(empty0), 1);
    chk("rst_ae0", 32'(ae0), 1);
    chk("rst_full0", 32'(full0), 0);
    chk("rst_af0", 32'(af0), 0);
    chk("rst_rd0", 32'(rd0), 0);
    chk("rst_rdv0", 32'(rdv0), 0);
    chk("rst_ovf0", 32'(ovf0), 0);
    chk("rst_unf0", 32'(unf0), 0);
    chk("rst_rdv1", 32'(rdv1), 0);
    chk("rst_rd1", 32'(rd1), 0);

    // Fill 0x00..0x0F with threshold sweep upward
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      chk_levels(i + 1);
      chk("fwft_head_fill", 32'(rd1), 32'h00);
      chk("fwft_rdv_fill", 32'(rdv1), 1);
    end
    wr_en = 1'b0;

    // Drain 16 in order, threshold sweep downward
    for (int i = 0; i < 16; i++) begin
      chk("fwft_head_drain", 32'(rd1), 32'(i));
      rd_en = 1'b1;
      step();
      chk("std_rd_drain", 32'(rd0), 32'(i));
      chk("std_rdv_drain", 32'(rdv0), 1);
      chk_levels(15 - i);
    end
    rd_en = 1'b0;
    step();
    chk("std_rdv_idle", 32'(rdv0), 0);
    chk("std_rd_hold", 32'(rd0), 32'h0F);
    chk("empty0_end", 32'(empty0), 1);
    chk("rdv1_empty", 32'(rdv1), 0);
    chk("unf0_clean", 32'(unf0), 0);

    // Simultaneous write/read on empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
    step();
    chk("empty_wr_count0", 32'(cnt0), 1);
    chk("empty_wr_unf0", 32'(unf0), 1);
    chk("empty_wr_unf1", 32'(unf1), 1);
    chk("empty_wr_rdv0", 32'(rdv0), 0);
    chk("empty_wr_rd1", 32'(rd1), 32'hA5);
    chk("empty_wr_rdv1", 32'(rdv1), 1);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("unf0_cleared", 32'(unf0), 0);
    chk("unf1_cleared", 32'(unf1), 0);

    // Refill to full: A5, 0x10..0x1E
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    chk("refill_full0", 32'(full0), 1);
    chk("refill_full1", 32'(full1), 1);

    // Simultaneous write/read on full
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    step();
    chk("full_both_rd0", 32'(rd0), 32'hA5);
    chk("full_both_rdv0", 32'(rdv0), 1);
    chk("full_both_count0", 32'(cnt0), 15);
    chk("full_both_ovf0", 32'(ovf0), 1);
    chk("full_both_ovf1", 32'(ovf1), 1);
    chk("full_both_head1", 32'(rd1), 32'h10);
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("ovf0_sticky", 32'(ovf0), 1);
    chk("count0_hold", 32'(cnt0), 15);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf0_cleared", 32'(ovf0), 0);
    chk("ovf1_cleared", 32'(ovf1), 0);

    // Drain to count 3, leaving 0x1C..0x1E
    for (int i = 0; i < 12; i++) begin
      rd_en = 1'b1;
      step();
      chk("pre_wrap_rd0", 32'(rd0), 32'(8'h10 + i));
    end
    rd_en = 1'b0;
    chk("pre_wrap_count0", 32'(cnt0), 3);
    q = '{8'h1C, 8'h1D, 8'h1E};

    // Streaming across pointer wraps
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h80 + k);
      step();
      exp_d = q.pop_front();
      q.push_back(8'(8'h80 + k));
      chk("wrap_rd0", 32'(rd0), 32'(exp_d));
      chk("wrap_rdv0", 32'(rdv0), 1);
      chk("wrap_head1", 32'(rd1), 32'(q[0]));
      chk("wrap_count0", 32'(cnt0), 3);
      chk("wrap_count1", 32'(cnt1), 3);
      chk("wrap_errs", 32'({ovf0, unf0, ovf1, unf1}), 0);
    end

    // Burst to count 5, then asynchronous reset between edges
    rd_en = 1'b0; wr_data = 8'h33;
    step();
    step();
    chk("burst_count0", 32'(cnt0), 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_count0", 32'(cnt0), 0);
    chk("arst_empty0", 32'(empty0), 1);
    chk("arst_count1", 32'(cnt1), 0);
    chk("arst_empty1", 32'(empty1), 1);
    chk("arst_rd0", 32'(rd0), 0);
    chk("arst_rdv0", 32'(rdv0), 0);
    chk("arst_rdv1", 32'(rdv1), 0);
    wr_en = 1'b0;
    step();
    rst = 1'b0;

    // Error set wins over simultaneous clear
    rd_en = 1'b1; err_clr = 1'b1;
    step();
    rd_en = 1'b0; err_clr = 1'b0;
    chk("setwins_unf0", 32'(unf0), 1);
    chk("setwins_unf1", 32'(unf1), 1);
    chk("setwins_count0", 32'(cnt0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
